// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_SRC AXI-Stream masters share one slave.
// The grant is held for a whole packet, then the scan resumes after the last
// served source. Once a source is granted, the data path is a plain combinational mux.
module axis_rr_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  input  logic [NUM_SRC-1:0]            s_tvalid_i,
  output logic [NUM_SRC-1:0]            s_tready_o,
  input  logic [NUM_SRC-1:0]            s_tlast_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata_i,
  output logic                          m_tvalid_o,
  input  logic                          m_tready_i,
  output logic                          m_tlast_o,
  output logic [DATA_WIDTH-1:0]         m_tdata_o,
  output logic [NUM_SRC-1:0]            grant_o,
  output logic                          busy_o,
  output logic [CNT_WIDTH-1:0]          beat_cnt_o,
  output logic [CNT_WIDTH-1:0]          pkt_cnt_o
);

  // state | meaning
  // IDLE  | no grant; pick the next requester after last_idx
  // XFER  | one source owns the slave until its tlast handshake
  localparam int         IDX_W   = $clog2(NUM_SRC);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     last_idx_q, last_idx_d;
  logic [CNT_WIDTH-1:0] beat_q, beat_d;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d;

  logic                 pick_vld;
  logic [NUM_SRC-1:0]   pick_oh;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 hs;
  int                   cand;

  // Round-robin pick: first valid source starting at last_idx+1, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_oh  = '0;
    cand     = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = (int'(last_idx_q) + k) % NUM_SRC;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!pick_vld && (i == cand) && s_tvalid_i[i]) begin
          pick_vld   = 1'b1;
          pick_oh[i] = 1'b1;
        end
      end
    end
  end

  // Output mux driven by the registered one-hot grant; all zero when idle.
  always_comb begin
    m_tvalid_o = 1'b0;
    m_tlast_o  = 1'b0;
    m_tdata_o  = '0;
    gnt_idx    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) begin
        m_tvalid_o = s_tvalid_i[i];
        m_tlast_o  = s_tlast_i[i];
        m_tdata_o  = s_tdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_idx    = IDX_W'(i);
      end
    end
  end

  assign s_tready_o = grant_q & {NUM_SRC{m_tready_i}};
  assign hs         = m_tvalid_o & m_tready_i;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q == ST_XFER);
  assign beat_cnt_o = beat_q;
  assign pkt_cnt_o  = pkt_q;

  // Next-state: arbitrate in IDLE, count beats and release on tlast in XFER.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_idx_d = last_idx_q;
    beat_d     = beat_q;
    pkt_d      = pkt_q;
    if (state_q == ST_IDLE) begin
      if (pick_vld) begin
        grant_d = pick_oh;
        state_d = ST_XFER;
      end
    end else if (hs) begin
      if (m_tlast_o) begin
        grant_d    = '0;
        state_d    = ST_IDLE;
        last_idx_d = gnt_idx;
        pkt_d      = pkt_q + 1'b1;
        beat_d     = '0;
      end else if (beat_q != '1) begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      last_idx_q <= IDX_W'(NUM_SRC - 1);
      beat_q     <= '0;
      pkt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_idx_q <= last_idx_d;
      beat_q     <= beat_d;
      pkt_q      <= pkt_d;
    end
  end

endmodule
